// File: rtl/seq_alu.sv
// Registered W-bit ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete at the accept edge; MUL is a W-iteration shift-add.
`timescale 1ns/1ps
module seq_alu #(
  parameter int W  = 32,
  parameter int SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow
);

  localparam int CW = SW + 1;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef enum logic {IDLE, MUL} state_e;

  state_e         state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   result_q, result_d;
  logic           zero_q, zero_d;
  logic           negative_q, negative_d;
  logic           carry_q, carry_d;
  logic           overflow_q, overflow_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           accept;
  logic [W:0]     sum_ext;
  logic [W-1:0]   alu_res;
  logic           alu_carry;
  logic           alu_ovf;
  logic [SW-1:0]  sh;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign sh       = b[SW-1:0];
  assign sum_ext  = {1'b0, a} + {1'b0, b};

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    unique case (op)
      4'b0000: alu_res = a;
      4'b0001: alu_res = ~a;
      4'b0010: begin
        alu_res   = sum_ext[W-1:0];
        alu_carry = sum_ext[W];
        alu_ovf   = (a[W-1] == b[W-1]) && (sum_ext[W-1] != a[W-1]);
      end
      4'b0011: begin
        alu_res   = a - b;
        alu_carry = (a < b);
        alu_ovf   = (a[W-1] != b[W-1]) && (alu_res[W-1] != a[W-1]);
      end
      4'b0100: alu_res = a | b;
      4'b0101: alu_res = a & b;
      4'b0110: alu_res = a ^ b;
      4'b0111: alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1000: alu_res = a << sh;
      4'b1001: alu_res = a >> sh;
      4'b1010: alu_res = $signed(a) >>> sh;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    // A consumed result drops valid unless something completes on this same edge.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            negative_d  = alu_res[W-1];
            carry_d     = alu_carry;
            overflow_d  = alu_ovf;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt_q == CW'(W)) begin
          result_d    = acc_q;
          zero_d      = (acc_q == '0);
          negative_d  = acc_q[W-1];
          carry_d     = 1'b0;
          overflow_d  = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (W=32): directed plan cases plus random ops against an arithmetic model.
`timescale 1ns/1ps
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         negative;
  logic         carry;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  seq_alu #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: signed results via 64-bit integers, products via a full 64-bit multiply.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, s;
    logic [63:0] p;
    int          sh;
    e  = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    case (o)
      4'd0:  e.r = x;
      4'd1:  e.r = ~x;
      4'd2: begin
        p   = {32'b0, x} + {32'b0, y};
        e.r = p[31:0];
        e.c = p[32];
        s   = sx + sy;
        e.v = (s > MAXS) || (s < MINS);
      end
      4'd3: begin
        e.r = x - y;
        e.c = (x < y);
        s   = sx - sy;
        e.v = (s > MAXS) || (s < MINS);
      end
      4'd4:  e.r = x | y;
      4'd5:  e.r = x & y;
      4'd6:  e.r = x ^ y;
      4'd7:  e.r = (sx < sy) ? 32'd1 : 32'd0;
      4'd8:  e.r = x << sh;
      4'd9:  e.r = x >> sh;
      4'd10: begin
        s   = sx >>> sh;
        e.r = s[31:0];
      end
      4'd11: begin
        p   = {32'b0, x} * {32'b0, y};
        e.r = p[31:0];
      end
      default: e.r = '0;
    endcase
    e.z = (e.r == 32'd0);
    e.n = e.r[31];
    return e;
  endfunction

  // Issues one op with out_ready=1 and returns the observed outputs, the number of
  // edges after the accept edge until out_valid, and how often in_ready was seen high while busy.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output exp_t obs, output int lat, output int busy_rdy);
    int waitc;
    waitc     = 0;
    op        = o;
    a         = x;
    b         = y;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    while (!in_ready && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 0;
    busy_rdy = 0;
    while (!out_valid && lat < 60) begin
      if (in_ready) busy_rdy++;
      @(posedge clk); #1;
      lat++;
    end
    obs = {result, zero, negative, carry, overflow};
  endtask

  task automatic test_reset();
    exp_t obs, exp_v;
    int   lat, br, ov_seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, result, zero, negative, carry, overflow} !== {1'b0, 1'b1, 32'd0, 4'b0}) begin
      errors++;
      $display("FAIL reset_init: got ov=%b rdy=%b res=%h flags=%b%b%b%b, want ov=0 rdy=1 res=0 flags=0000",
               out_valid, in_ready, result, zero, negative, carry, overflow);
    end
    op = 4'b1011; a = 32'h1234; b = 32'h5678; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, result, zero, negative, carry, overflow} !== {1'b0, 1'b1, 32'd0, 4'b0}) begin
      errors++;
      $display("FAIL reset_mid_mul: got ov=%b rdy=%b res=%h flags=%b%b%b%b, want ov=0 rdy=1 res=0 flags=0000",
               out_valid, in_ready, result, zero, negative, carry, overflow);
    end
    ov_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    checks++;
    if (ov_seen !== 0) begin
      errors++;
      $display("FAIL reset_abandon: out_valid seen %0d times, want 0", ov_seen);
    end
    issue(4'b0010, 32'd5, 32'd7, obs, lat, br);
    exp_v = {32'd12, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v || lat !== 0) begin
      errors++;
      $display("FAIL add_after_reset: got %h lat %0d, want %h lat 0", obs, lat, exp_v);
    end
  endtask

  task automatic test_arith();
    exp_t obs;
    int   lat, br;
    exp_t exp_v [5];
    logic [3:0]  ops [5];
    logic [31:0] as  [5];
    logic [31:0] bs  [5];
    ops[0] = 4'b0010; as[0] = 32'h7FFFFFFF; bs[0] = 32'd1; exp_v[0] = {32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    ops[1] = 4'b0010; as[1] = 32'hFFFFFFFF; bs[1] = 32'd1; exp_v[1] = {32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    ops[2] = 4'b0011; as[2] = 32'd3;        bs[2] = 32'd5; exp_v[2] = {32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 1'b0};
    ops[3] = 4'b0011; as[3] = 32'h80000000; bs[3] = 32'd1; exp_v[3] = {32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    ops[4] = 4'b0111; as[4] = 32'hFFFFFFFF; bs[4] = 32'd1; exp_v[4] = {32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i], obs, lat, br);
      checks++;
      if (obs !== exp_v[i] || lat !== 0) begin
        errors++;
        $display("FAIL arith_%0d op=%b: got %h lat %0d, want %h lat 0", i, ops[i], obs, lat, exp_v[i]);
      end
    end
  endtask

  task automatic test_shift();
    exp_t obs;
    int   lat, br;
    exp_t exp_v [3];
    exp_v[0] = {32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_v[1] = {32'h08000001, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_v[2] = {32'hF8000001, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      issue(4'(8 + i), 32'h80000010, 32'd4, obs, lat, br);
      checks++;
      if (obs !== exp_v[i] || lat !== 0) begin
        errors++;
        $display("FAIL shift_%0d: got %h lat %0d, want %h lat 0", i, obs, lat, exp_v[i]);
      end
    end
  endtask

  task automatic test_mul();
    exp_t obs, exp_v;
    int   lat, br;
    issue(4'b1011, 32'h00010001, 32'h00000003, obs, lat, br);
    exp_v = {32'h00030003, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v || lat !== 33 || br !== 0) begin
      errors++;
      $display("FAIL mul_small: got %h lat %0d busy_ready %0d, want %h lat 33 busy_ready 0", obs, lat, br, exp_v);
    end
    issue(4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, obs, lat, br);
    exp_v = {32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v || lat !== 33 || br !== 0) begin
      errors++;
      $display("FAIL mul_max: got %h lat %0d busy_ready %0d, want %h lat 33 busy_ready 0", obs, lat, br, exp_v);
    end
  endtask

  task automatic test_random();
    exp_t        obs, exp_v;
    int          lat, br, want_lat;
    logic [3:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 120; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      if (i % 7 == 0) x = 32'h80000000;
      if (i % 11 == 0) y = x;
      if (i % 13 == 0) y = 32'hFFFFFFFF;
      issue(o, x, y, obs, lat, br);
      exp_v    = model(o, x, y);
      want_lat = (o == 4'b1011) ? 33 : 0;
      checks++;
      if (obs !== exp_v || lat !== want_lat || br !== 0) begin
        errors++;
        $display("FAIL random_%0d op=%b a=%h b=%h: got %h lat %0d busy_ready %0d, want %h lat %0d",
                 i, o, x, y, obs, lat, br, exp_v, want_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        obs, exp_v;
    logic [3:0]  o;
    logic [31:0] x, y;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      o = 4'($urandom_range(0, 10));
      if (o == 4'b1011) o = 4'b0110;
      x = $urandom;
      y = $urandom;
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      obs   = {result, zero, negative, carry, overflow};
      exp_v = model(o, x, y);
      checks++;
      if (obs !== exp_v || out_valid !== 1'b1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d op=%b: got %h ov=%b rdy=%b, want %h ov=1 rdy=1", i, o, obs, out_valid, in_ready, exp_v);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    exp_t obs, exp_v;
    op = 4'b0010; a = 32'd1; b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    @(posedge clk); #1;
    op = 4'b0110; a = 32'h000000F0; b = 32'h000000FF;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'd2}) begin
        errors++;
        $display("FAIL hold_%0d: got ov=%b rdy=%b res=%h, want ov=1 rdy=0 res=2", i, out_valid, in_ready, result);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: got rdy=%b, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    obs   = {result, zero, negative, carry, overflow};
    exp_v = {32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL xor_after_release: got %h ov=%b, want %h ov=1", obs, out_valid, exp_v);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0000000F) begin
      errors++;
      $display("FAIL valid_clear: got ov=%b res=%h, want ov=0 res=0000000f", out_valid, result);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
